ue_icu_n: RTL

- Parametrised successor to the single-bit UE14500 control unit: MC14500-compatible ICU with a data path DW bits wide.
- Executes one 4-bit instruction per rising clock edge.
- Drives the result register, the write strobe and the JMP/RTN/FLAG pulses, plus an optional internal program counter.
- Sits behind the TinyTapeout io wrapper; the wrapper maps io_in[0] to clk and io_in[1] to rst.

---
 rtl/ue_pkg.sv | 10 +
 rtl/ue_icu_n_if.sv | 25 ++
 rtl/ue_icu_pc.sv | 22 ++
 rtl/ue_icu_n.sv | 67 ++++++
 4 files changed

// File: rtl/ue_pkg.sv
// ue_pkg: shared opcode enum, default widths and reset values for the ue_icu_n ICU
package ue_pkg;
  typedef enum logic [3:0] {
    OP_NOPO, OP_LD, OP_LDC, OP_AND, OP_ANDC, OP_OR, OP_ORC, OP_XNOR,
    OP_STO, OP_STOC, OP_IEN, OP_OEN, OP_JMP, OP_RTN, OP_SKZ, OP_NOPF
  } op_e;
  localparam int DW_DEF = 1;
  localparam int AW_DEF = 4;
  localparam logic RST_BIT = 1'b0;
endpackage

// File: rtl/ue_icu_n_if.sv
// ue_icu_n_if: instruction/data bus and registered status outputs of the ue_icu_n ICU
interface ue_icu_n_if import ue_pkg::*; #(parameter int DW = DW_DEF, parameter int AW = AW_DEF);
  logic [3:0] instr;
  logic [AW-1:0] addr;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;
  logic write;
  logic [DW-1:0] rr;
  logic ien;
  logic oen;
  logic jmp;
  logic rtn;
  logic flag0;
  logic flagf;
  logic skip;
  logic [AW-1:0] pc;
  modport master (
    output instr, addr, data_in,
    input data_out, write, rr, ien, oen, jmp, rtn, flag0, flagf, skip, pc
  );
  modport slave (
    input instr, addr, data_in,
    output data_out, write, rr, ien, oen, jmp, rtn, flag0, flagf, skip, pc
  );
endinterface

// File: rtl/ue_icu_pc.sv
// ue_icu_pc: program counter and link register, built only when UE_ICU_PC_EN is defined
`ifdef UE_ICU_PC_EN
module ue_icu_pc import ue_pkg::*; #(parameter int AW = AW_DEF) (
  input logic clk,
  input logic rst,
  input logic jmp,
  input logic rtn,
  input logic [AW-1:0] addr,
  output logic [AW-1:0] pc
);
  logic [AW-1:0] link;
  // pc steps every cycle; executed JMP loads addr and saves the return point, executed RTN reloads it
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pc <= {AW{RST_BIT}};
      link <= {AW{RST_BIT}};
    end else begin
      pc <= jmp ? addr : rtn ? link : pc + 1'b1;
      link <= jmp ? pc + 1'b1 : link;
    end
endmodule
`endif

// File: rtl/ue_icu_n.sv
// ue_icu_n: DW-wide MC14500-style ICU core; UE_ICU_PC_EN adds an internal pc/link sequencer
module ue_icu_n import ue_pkg::*; #(parameter int DW = DW_DEF, parameter int AW = AW_DEF) (
  input logic clk,
  input logic rst,
  ue_icu_n_if.slave bus
);
  op_e op;
  logic ex;
  logic stb;
  logic [DW-1:0] dg;
  logic [DW-1:0] rr_nx;
  assign op = op_e'(bus.instr);
  assign ex = ~bus.skip;
  assign dg = bus.ien ? bus.data_in : '0;
  assign stb = ex & bus.oen & ((op == OP_STO) | (op == OP_STOC));
  // result-register next value for the logic opcodes; everything else holds rr
  always_comb begin
    rr_nx = bus.rr;
    case (op)
      OP_LD:   rr_nx = dg;
      OP_LDC:  rr_nx = ~dg;
      OP_AND:  rr_nx = bus.rr & dg;
      OP_ANDC: rr_nx = bus.rr & ~dg;
      OP_OR:   rr_nx = bus.rr | dg;
      OP_ORC:  rr_nx = bus.rr | ~dg;
      OP_XNOR: rr_nx = ~(bus.rr ^ dg);
      default: rr_nx = bus.rr;
    endcase
  end
  // architectural registers and one-cycle pulses; a discarded instruction only clears skip
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bus.rr <= {DW{RST_BIT}};
      bus.data_out <= {DW{RST_BIT}};
      bus.ien <= RST_BIT;
      bus.oen <= RST_BIT;
      bus.skip <= RST_BIT;
      bus.write <= RST_BIT;
      bus.jmp <= RST_BIT;
      bus.rtn <= RST_BIT;
      bus.flag0 <= RST_BIT;
      bus.flagf <= RST_BIT;
    end else begin
      bus.rr <= ex ? rr_nx : bus.rr;
      bus.data_out <= stb ? ((op == OP_STOC) ? ~bus.rr : bus.rr) : bus.data_out;
      bus.write <= stb;
      bus.ien <= (ex & (op == OP_IEN)) ? bus.data_in[0] : bus.ien;
      bus.oen <= (ex & (op == OP_OEN)) ? bus.data_in[0] : bus.oen;
      bus.jmp <= ex & (op == OP_JMP);
      bus.rtn <= ex & (op == OP_RTN);
      bus.flag0 <= ex & (op == OP_NOPO);
      bus.flagf <= ex & (op == OP_NOPF);
      bus.skip <= ex & ((op == OP_RTN) | ((op == OP_SKZ) & (bus.rr == '0)));
    end
`ifdef UE_ICU_PC_EN
  ue_icu_pc #(.AW(AW)) u_pc (
    .clk(clk),
    .rst(rst),
    .jmp(ex & (op == OP_JMP)),
    .rtn(ex & (op == OP_RTN)),
    .addr(bus.addr),
    .pc(bus.pc)
  );
`else
  assign bus.pc = '0;
`endif
endmodule
